time_counter: RTL and testbench
===============================

// Module: time_counter
// PURPOSE
//  Running timekeeper that consumes the six BCD digits produced by the time-set FSM.
//  Loads them on a load strobe, then advances hh:mm:ss once per second, wrapping 23:59:59->00:00:00.
//  Drives the display path and downstream day/alarm logic.
// PARAMETERS
//  DIV      100_000_000  clk cycles per second tick (>=2)
//  ALM_SECS 10           seconds alarm stays asserted (ALARM_EN only)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high
//  load       in   1  1-cycle strobe: capture ld_* digits
//  hold       in   1  freeze counting (set FSM editing)
//  ld_hour1   in   2  ld_hour2 in 4 | ld_min1 in 3 | ld_min2 in 4 | ld_sec1 in 3 | ld_sec2 in 4
//  hour1      out  2  hour2 out 4 | min1 out 3 | min2 out 4 | sec1 out 3 | sec2 out 4 (BCD)
//  running    out  1  1 = valid time loaded and counting enabled
//  sec_pulse  out  1  1-cycle pulse on each second advance
//  day_pulse  out  1  1-cycle pulse on 23:59:59->00:00:00
//  load_err   out  1  1-cycle pulse: load rejected (invalid digits)
//  alm_en     in   1  alarm arm | alm_h1 in 2, alm_h2 in 4, alm_m1 in 3, alm_m2 in 4
//  alm_ack    in   1  clears alarm | alarm out 1 alarm active
// BEHAVIOUR
//  Reset: all digits 0, running=0, all pulses 0, alarm=0, prescaler=0, state STOPPED.
//  States: STOPPED (no counting, prescaler held 0) -> RUN on valid load; RUN stays RUN.
//  Load valid iff hour<=23 (hour1<=2; hour2<=9, <=3 when hour1==2), min1/sec1<=5, min2/sec2<=9.
//  Valid load: digits registered next edge, prescaler cleared, running=1 next cycle.
//  Invalid load: digits and state unchanged, load_err pulses next cycle.
//  Prescaler counts 0..DIV-1 in RUN when hold=0; at DIV-1 wraps to 0 and a tick occurs.
//  Tick: sec2 +1; 9->0 carries to sec1; sec1 5->0 carries to min2; same for min; min carry
//   increments hours; hour 23->00 raises day_pulse. All digits update on the same edge;
//   sec_pulse asserted in the cycle after the update (registered).
//  hold=1: prescaler and digits frozen, running=0; release resumes from frozen count.
//  load and tick same cycle: load wins, tick discarded, prescaler cleared.
//  load during hold: accepted (valid check applies); running stays 0 until hold released.
//  Reset mid-operation: immediate return to reset values, pending pulses dropped.
// CONFIGURATION
//  ALARM_EN defined: when alm_en=1 and a tick makes time == alm hh:mm:00, alarm=1 for
//   ALM_SECS ticks or until alm_ack (ack wins over set same cycle); re-trigger restarts count.
//  ALARM_EN undefined: alarm tied 0, alm_* inputs ignored, no alarm registers.
// STRUCTURE
//  clock_pkg: digit widths, max-digit constants (9,5,2,3), state encoding STOPPED/RUN.
//  Sub-module bcd_digit_counter #(MAX,W): inc, clr, load value -> digit, carry_out
//   (carry when inc at MAX); instantiated for sec2/sec1/min2/min1; hours handled in top.
// TESTING (DIV=4, ALM_SECS=3)
//  reset, no load, 20 clks -> digits 00:00:00, running=0, no sec_pulse.
//  load 12:34:56 -> running=1; after 16 clks time 12:35:00, 4 sec_pulses, spaced 4 clks.
//  load 23:59:58 -> after 2 ticks 00:00:00, day_pulse exactly once.
//  load 24:00:00 and 10:60:00 -> load_err each, digits unchanged, state unchanged.
//  hold=1 for 10 clks mid-count -> digits frozen, running=0; release -> resumes same phase.
//  ALARM_EN: alm 07:00, load 06:59:58, 2 ticks -> alarm=1; 3 ticks later alarm=0; ack clears early.

Source files
------------

// File: rtl/time_counter_pkg.sv
// ---------------------------------------------------------------------------
// time_counter_pkg : digit widths, digit limits, run-state encoding, load check
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package time_counter_pkg;

   localparam int unsigned c_H1_W   = 2;
   localparam int unsigned c_UNIT_W = 4;
   localparam int unsigned c_TENS_W = 3;

   localparam int unsigned c_MAX_UNIT     = 9;
   localparam int unsigned c_MAX_TENS     = 5;
   localparam int unsigned c_MAX_H1       = 2;
   localparam int unsigned c_MAX_H2_AT_20 = 3;

   typedef logic [0:0] state_t;
   localparam state_t c_ST_STOPPED = 1'b0;
   localparam state_t c_ST_RUN     = 1'b1;

   function automatic logic time_valid(
      input logic [c_H1_W-1:0]   h1,
      input logic [c_UNIT_W-1:0] h2,
      input logic [c_TENS_W-1:0] m1,
      input logic [c_UNIT_W-1:0] m2,
      input logic [c_TENS_W-1:0] s1,
      input logic [c_UNIT_W-1:0] s2
   );
      logic [c_UNIT_W-1:0] h2_max;
      h2_max = (h1 == c_H1_W'(c_MAX_H1)) ? c_UNIT_W'(c_MAX_H2_AT_20) : c_UNIT_W'(c_MAX_UNIT);
      return (h1 <= c_H1_W'(c_MAX_H1)) && (h2 <= h2_max)
          && (m1 <= c_TENS_W'(c_MAX_TENS)) && (m2 <= c_UNIT_W'(c_MAX_UNIT))
          && (s1 <= c_TENS_W'(c_MAX_TENS)) && (s2 <= c_UNIT_W'(c_MAX_UNIT));
   endfunction

endpackage

`default_nettype wire

// File: rtl/time_counter_if.sv
// ---------------------------------------------------------------------------
// time_counter_if : load/hold/alarm controls and BCD time outputs of the timekeeper
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface time_counter_if;
   import time_counter_pkg::*;

   logic                load;
   logic                hold;
   logic [c_H1_W-1:0]   ld_hour1;
   logic [c_UNIT_W-1:0] ld_hour2;
   logic [c_TENS_W-1:0] ld_min1;
   logic [c_UNIT_W-1:0] ld_min2;
   logic [c_TENS_W-1:0] ld_sec1;
   logic [c_UNIT_W-1:0] ld_sec2;
   logic [c_H1_W-1:0]   hour1;
   logic [c_UNIT_W-1:0] hour2;
   logic [c_TENS_W-1:0] min1;
   logic [c_UNIT_W-1:0] min2;
   logic [c_TENS_W-1:0] sec1;
   logic [c_UNIT_W-1:0] sec2;
   logic                running;
   logic                sec_pulse;
   logic                day_pulse;
   logic                load_err;
   logic                alm_en;
   logic [c_H1_W-1:0]   alm_h1;
   logic [c_UNIT_W-1:0] alm_h2;
   logic [c_TENS_W-1:0] alm_m1;
   logic [c_UNIT_W-1:0] alm_m2;
   logic                alm_ack;
   logic                alarm;

   modport slave (
      input  load, hold, ld_hour1, ld_hour2, ld_min1, ld_min2, ld_sec1, ld_sec2,
      input  alm_en, alm_h1, alm_h2, alm_m1, alm_m2, alm_ack,
      output hour1, hour2, min1, min2, sec1, sec2,
      output running, sec_pulse, day_pulse, load_err, alarm
   );

   modport master (
      output load, hold, ld_hour1, ld_hour2, ld_min1, ld_min2, ld_sec1, ld_sec2,
      output alm_en, alm_h1, alm_h2, alm_m1, alm_m2, alm_ack,
      input  hour1, hour2, min1, min2, sec1, sec2,
      input  running, sec_pulse, day_pulse, load_err, alarm
   );

endinterface

`default_nettype wire

// File: rtl/time_counter_bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter : one BCD digit with clear/load/increment and carry at MAX
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_digit_counter #(
   parameter int unsigned MAX = 9,
   parameter int unsigned W   = 4
) (
   input  wire logic         clk,
   input  wire logic         reset,
   input  wire logic         inc_i,
   input  wire logic         clr_i,
   input  wire logic         ld_i,
   input  wire logic [W-1:0] ld_val_i,
   output logic      [W-1:0] digit_o,
   output logic              carry_o
);

   localparam logic [W-1:0] c_MAX = W'(MAX);

   logic [W-1:0] digit_q;
   logic [W-1:0] digit_d;

   assign carry_o = inc_i && (digit_q == c_MAX);
   assign digit_o = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (clr_i) begin
         digit_d = '0;
      end else if (ld_i) begin
         digit_d = ld_val_i;
      end else if (inc_i) begin
         digit_d = (digit_q == c_MAX) ? '0 : digit_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter : loadable hh:mm:ss BCD timekeeper with optional alarm (ALARM_EN)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module time_counter
   import time_counter_pkg::*;
#(
   parameter int unsigned DIV      = 100_000_000,
   parameter int unsigned ALM_SECS = 10
) (
   input wire logic     clk,
   input wire logic     reset,
   time_counter_if.slave bus
);

   localparam int unsigned      c_PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [c_PW-1:0]  c_PMAX = c_PW'(DIV - 1);

   state_t              state_q, state_d;
   logic [c_PW-1:0]     presc_q, presc_d;
   logic [c_H1_W-1:0]   hour1_q, hour1_d;
   logic [c_UNIT_W-1:0] hour2_q, hour2_d;
   logic                sec_pulse_q, day_pulse_q, load_err_q;

   logic                w_ld_valid, w_ld_bad, w_cnt_en, w_tick;
   logic                w_c_sec2, w_c_sec1, w_c_min2, w_hr_inc, w_day_wrap;

   assign w_ld_valid = bus.load && time_valid(bus.ld_hour1, bus.ld_hour2, bus.ld_min1,
                                              bus.ld_min2, bus.ld_sec1, bus.ld_sec2);
   assign w_ld_bad   = bus.load && !w_ld_valid;
   // A valid load on the tick cycle wins: the tick is dropped entirely.
   assign w_tick     = w_cnt_en && (presc_q == c_PMAX) && !w_ld_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= c_ST_STOPPED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_STOPPED: if (w_ld_valid) state_d = c_ST_RUN;
         c_ST_RUN:     state_d = c_ST_RUN;
         default:      state_d = c_ST_STOPPED;
      endcase
   end

   always_comb begin
      w_cnt_en = 1'b0;
      if (state_q == c_ST_RUN && !bus.hold) begin
         w_cnt_en = 1'b1;
      end
   end

   always_comb begin
      presc_d = presc_q;
      if (w_ld_valid || state_q == c_ST_STOPPED) begin
         presc_d = '0;
      end else if (w_cnt_en) begin
         presc_d = (presc_q == c_PMAX) ? '0 : presc_q + 1'b1;
      end
   end

   bcd_digit_counter #(.MAX(c_MAX_UNIT), .W(c_UNIT_W)) u_sec2 (
      .clk(clk), .reset(reset), .inc_i(w_tick), .clr_i(1'b0), .ld_i(w_ld_valid),
      .ld_val_i(bus.ld_sec2), .digit_o(bus.sec2), .carry_o(w_c_sec2)
   );
   bcd_digit_counter #(.MAX(c_MAX_TENS), .W(c_TENS_W)) u_sec1 (
      .clk(clk), .reset(reset), .inc_i(w_c_sec2), .clr_i(1'b0), .ld_i(w_ld_valid),
      .ld_val_i(bus.ld_sec1), .digit_o(bus.sec1), .carry_o(w_c_sec1)
   );
   bcd_digit_counter #(.MAX(c_MAX_UNIT), .W(c_UNIT_W)) u_min2 (
      .clk(clk), .reset(reset), .inc_i(w_c_sec1), .clr_i(1'b0), .ld_i(w_ld_valid),
      .ld_val_i(bus.ld_min2), .digit_o(bus.min2), .carry_o(w_c_min2)
   );
   bcd_digit_counter #(.MAX(c_MAX_TENS), .W(c_TENS_W)) u_min1 (
      .clk(clk), .reset(reset), .inc_i(w_c_min2), .clr_i(1'b0), .ld_i(w_ld_valid),
      .ld_val_i(bus.ld_min1), .digit_o(bus.min1), .carry_o(w_hr_inc)
   );

   // Hours are a single 00..23 counter, so the tens digit limit depends on the units.
   assign w_day_wrap = w_hr_inc && (hour1_q == c_H1_W'(c_MAX_H1))
                    && (hour2_q == c_UNIT_W'(c_MAX_H2_AT_20));

   always_comb begin
      hour1_d = hour1_q;
      hour2_d = hour2_q;
      if (w_ld_valid) begin
         hour1_d = bus.ld_hour1;
         hour2_d = bus.ld_hour2;
      end else if (w_day_wrap) begin
         hour1_d = '0;
         hour2_d = '0;
      end else if (w_hr_inc) begin
         if (hour2_q == c_UNIT_W'(c_MAX_UNIT)) begin
            hour2_d = '0;
            hour1_d = hour1_q + 1'b1;
         end else begin
            hour2_d = hour2_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q     <= '0;
         hour1_q     <= '0;
         hour2_q     <= '0;
         sec_pulse_q <= 1'b0;
         day_pulse_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         presc_q     <= presc_d;
         hour1_q     <= hour1_d;
         hour2_q     <= hour2_d;
         sec_pulse_q <= w_tick;
         day_pulse_q <= w_day_wrap;
         load_err_q  <= w_ld_bad;
      end
   end

   assign bus.hour1     = hour1_q;
   assign bus.hour2     = hour2_q;
   assign bus.running   = w_cnt_en;
   assign bus.sec_pulse = sec_pulse_q;
   assign bus.day_pulse = day_pulse_q;
   assign bus.load_err  = load_err_q;

`ifdef ALARM_EN
   localparam int unsigned c_AW = $clog2(ALM_SECS + 1);

   logic            alarm_q, alarm_d;
   logic [c_AW-1:0] alm_cnt_q, alm_cnt_d;
   logic            w_alm_hit;

   // Compared in the cycle after the update, when the new time is on the outputs.
   assign w_alm_hit = bus.alm_en && sec_pulse_q
                   && ({hour1_q, hour2_q, bus.min1, bus.min2}
                       == {bus.alm_h1, bus.alm_h2, bus.alm_m1, bus.alm_m2})
                   && (bus.sec1 == '0) && (bus.sec2 == '0);

   always_comb begin
      alarm_d   = alarm_q;
      alm_cnt_d = alm_cnt_q;
      if (bus.alm_ack) begin
         alarm_d   = 1'b0;
         alm_cnt_d = '0;
      end else if (w_alm_hit) begin
         alarm_d   = 1'b1;
         alm_cnt_d = c_AW'(ALM_SECS);
      end else if (alarm_q && sec_pulse_q) begin
         if (alm_cnt_q <= c_AW'(1)) begin
            alarm_d   = 1'b0;
            alm_cnt_d = '0;
         end else begin
            alm_cnt_d = alm_cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm_q   <= 1'b0;
         alm_cnt_q <= '0;
      end else begin
         alarm_q   <= alarm_d;
         alm_cnt_q <= alm_cnt_d;
      end
   end

   assign bus.alarm = alarm_q;
`else
   assign bus.alarm = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_time_counter.sv
// ---------------------------------------------------------------------------
// tb_time_counter : scenario tasks with an expected-time queue for time_counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_time_counter;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;
   logic [19:0] exp_q[$];
   logic [19:0] now;

`ifdef ALARM_EN
   localparam logic ALM = 1'b1;
`else
   localparam logic ALM = 1'b0;
`endif

   time_counter_if bus();

   time_counter #(.DIV(4), .ALM_SECS(3)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   assign now = {bus.hour1, bus.hour2, bus.min1, bus.min2, bus.sec1, bus.sec2};

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   function automatic logic [19:0] bcd_of(input int t);
      int h, m, s;
      t = t % 86400;
      h = t / 3600;
      m = (t / 60) % 60;
      s = t % 60;
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
   endfunction

   function automatic int secs(input int h, input int m, input int s);
      return h * 3600 + m * 60 + s;
   endfunction

   task automatic load_raw(input logic [1:0] h1, input logic [3:0] h2, input logic [2:0] m1,
                           input logic [3:0] m2, input logic [2:0] s1, input logic [3:0] s2);
      @(negedge clk);
      bus.ld_hour1 = h1; bus.ld_hour2 = h2; bus.ld_min1 = m1;
      bus.ld_min2  = m2; bus.ld_sec1  = s1; bus.ld_sec2 = s2;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic load_secs(input int t);
      logic [19:0] v;
      v = bcd_of(t);
      load_raw(v[19:18], v[17:14], v[13:11], v[10:7], v[6:4], v[3:0]);
   endtask

   task automatic test_reset;
      int pulses;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.sec_pulse || bus.day_pulse || bus.load_err) pulses++;
      end
      checks++;
      if (now !== 20'h0) begin errors++; $display("FAIL reset_time: got %h expected %h", now, 20'h0); end
      checks++;
      if (bus.running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", bus.running); end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL reset_pulses: got %0d expected 0", pulses); end
      checks++;
      if (bus.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b expected 0", bus.alarm); end
   endtask

   task automatic test_count;
      int t0, pulses, last;
      logic [19:0] e;
      t0 = secs(12, 34, 56);
      exp_q.delete();
      load_secs(t0);
      for (int k = 1; k <= 4; k++) exp_q.push_back(bcd_of(t0 + k));
      checks++;
      if (bus.running !== 1'b1 || now !== bcd_of(t0)) begin
         errors++; $display("FAIL count_load: got run=%b time=%h expected run=1 time=%h", bus.running, now, bcd_of(t0));
      end
      pulses = 0; last = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (bus.sec_pulse) begin
            pulses++;
            checks++;
            if (c - last != 4) begin errors++; $display("FAIL count_spacing: got %0d expected 4", c - last); end
            last = c;
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL count_extra_pulse: got pulse at cycle %0d expected none", c);
            end else begin
               e = exp_q.pop_front();
               if (now !== e) begin errors++; $display("FAIL count_time: got %h expected %h", now, e); end
            end
         end
      end
      checks++;
      if (pulses != 4) begin errors++; $display("FAIL count_pulses: got %0d expected 4", pulses); end
      checks++;
      if (now !== bcd_of(secs(12, 35, 0))) begin
         errors++; $display("FAIL count_final: got %h expected %h", now, bcd_of(secs(12, 35, 0)));
      end
   endtask

   task automatic test_day;
      int t0, days;
      logic [19:0] e;
      t0 = secs(23, 59, 58);
      exp_q.delete();
      load_secs(t0);
      exp_q.push_back(bcd_of(t0 + 1));
      exp_q.push_back(bcd_of(t0 + 2));
      days = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (bus.day_pulse) begin
            days++;
            checks++;
            if (now !== 20'h0) begin errors++; $display("FAIL day_pulse_time: got %h expected %h", now, 20'h0); end
         end
         if (bus.sec_pulse && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (now !== e) begin errors++; $display("FAIL day_time: got %h expected %h", now, e); end
         end
      end
      checks++;
      if (days != 1) begin errors++; $display("FAIL day_count: got %0d expected 1", days); end
      checks++;
      if (exp_q.size() != 0 || now !== 20'h0) begin
         errors++; $display("FAIL day_final: got %h left=%0d expected 000000 left=0", now, exp_q.size());
      end
   endtask

   task automatic test_invalid;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      load_raw(2'd2, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0);
      checks++;
      if (bus.load_err !== 1'b1 || now !== 20'h0 || bus.running !== 1'b0) begin
         errors++; $display("FAIL invalid_hour: got err=%b time=%h run=%b expected err=1 time=00000 run=0", bus.load_err, now, bus.running);
      end
      @(negedge clk);
      checks++;
      if (bus.load_err !== 1'b0) begin errors++; $display("FAIL invalid_err_width: got %b expected 0", bus.load_err); end
      load_raw(2'd1, 4'd0, 3'd6, 4'd0, 3'd0, 4'd0);
      checks++;
      if (bus.load_err !== 1'b1 || now !== 20'h0 || bus.running !== 1'b0) begin
         errors++; $display("FAIL invalid_min: got err=%b time=%h run=%b expected err=1 time=00000 run=0", bus.load_err, now, bus.running);
      end
      load_secs(secs(5, 0, 0));
      load_raw(2'd2, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0);
      checks++;
      if (bus.load_err !== 1'b1 || now !== bcd_of(secs(5, 0, 0)) || bus.running !== 1'b1) begin
         errors++; $display("FAIL invalid_running: got err=%b time=%h run=%b expected err=1 time=%h run=1", bus.load_err, now, bus.running, bcd_of(secs(5, 0, 0)));
      end
   endtask

   task automatic test_hold;
      int bad, k;
      logic [19:0] e;
      exp_q.delete();
      load_secs(secs(8, 0, 0));
      repeat (2) @(negedge clk);
      bus.hold = 1'b1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (now !== bcd_of(secs(8, 0, 0)) || bus.running !== 1'b0 || bus.sec_pulse !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL hold_frozen: got %0d bad cycles expected 0", bad); end
      bus.hold = 1'b0;
      exp_q.push_back(bcd_of(secs(8, 0, 1)));
      k = 0;
      for (int c = 1; c <= 8 && k == 0; c++) begin
         @(negedge clk);
         if (bus.sec_pulse) k = c;
      end
      checks++;
      if (k != 2) begin errors++; $display("FAIL hold_phase: got pulse at %0d expected 2", k); end
      e = exp_q.pop_front();
      checks++;
      if (now !== e || bus.running !== 1'b1) begin
         errors++; $display("FAIL hold_resume: got %h run=%b expected %h run=1", now, bus.running, e);
      end
   endtask

   task automatic test_back_to_back;
      int k;
      logic [19:0] e;
      exp_q.delete();
      load_secs(secs(10, 0, 0));
      repeat (2) @(negedge clk);
      load_secs(secs(11, 11, 11));
      checks++;
      if (now !== bcd_of(secs(11, 11, 11)) || bus.sec_pulse !== 1'b0) begin
         errors++; $display("FAIL b2b_load_wins: got %h pulse=%b expected %h pulse=0", now, bus.sec_pulse, bcd_of(secs(11, 11, 11)));
      end
      exp_q.push_back(bcd_of(secs(11, 11, 12)));
      k = 0;
      for (int c = 1; c <= 8 && k == 0; c++) begin
         @(negedge clk);
         if (bus.sec_pulse) k = c;
      end
      e = exp_q.pop_front();
      checks++;
      if (k != 4 || now !== e) begin
         errors++; $display("FAIL b2b_restart: got pulse at %0d time %h expected 4 time %h", k, now, e);
      end
   endtask

   task automatic test_mid_reset;
      load_secs(secs(12, 0, 0));
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (now !== 20'h0 || bus.running !== 1'b0 || bus.sec_pulse !== 1'b0) begin
         errors++; $display("FAIL mid_reset: got %h run=%b pulse=%b expected 00000 run=0 pulse=0", now, bus.running, bus.sec_pulse);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_alarm;
      int got;
      bus.alm_en = 1'b1;
      bus.alm_h1 = 2'd0; bus.alm_h2 = 4'd7; bus.alm_m1 = 3'd0; bus.alm_m2 = 4'd0;
      load_secs(secs(6, 59, 58));
      got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         @(negedge clk);
         if (bus.sec_pulse) got++;
      end
      @(negedge clk);
      checks++;
      if (got != 2 || bus.alarm !== ALM) begin
         errors++; $display("FAIL alarm_set: got ticks=%0d alarm=%b expected ticks=2 alarm=%b", got, bus.alarm, ALM);
      end
      got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         @(negedge clk);
         if (bus.sec_pulse) got++;
      end
      checks++;
      if (bus.alarm !== ALM) begin errors++; $display("FAIL alarm_hold: got %b expected %b", bus.alarm, ALM); end
      for (int c = 0; c < 20 && got < 3; c++) begin
         @(negedge clk);
         if (bus.sec_pulse) got++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (got != 3 || bus.alarm !== 1'b0) begin
         errors++; $display("FAIL alarm_expire: got ticks=%0d alarm=%b expected ticks=3 alarm=0", got, bus.alarm);
      end
      load_secs(secs(6, 59, 58));
      got = 0;
      for (int c = 0; c < 20 && got < 2; c++) begin
         @(negedge clk);
         if (bus.sec_pulse) got++;
      end
      @(negedge clk);
      checks++;
      if (bus.alarm !== ALM) begin errors++; $display("FAIL alarm_reset2: got %b expected %b", bus.alarm, ALM); end
      bus.alm_ack = 1'b1;
      @(negedge clk);
      bus.alm_ack = 1'b0;
      checks++;
      if (bus.alarm !== 1'b0) begin errors++; $display("FAIL alarm_ack: got %b expected 0", bus.alarm); end
      bus.alm_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.load = 1'b0; bus.hold = 1'b0;
      bus.ld_hour1 = '0; bus.ld_hour2 = '0; bus.ld_min1 = '0;
      bus.ld_min2  = '0; bus.ld_sec1  = '0; bus.ld_sec2 = '0;
      bus.alm_en = 1'b0; bus.alm_ack = 1'b0;
      bus.alm_h1 = '0; bus.alm_h2 = '0; bus.alm_m1 = '0; bus.alm_m2 = '0;
      test_reset();
      test_count();
      test_day();
      test_invalid();
      test_hold();
      test_back_to_back();
      test_mid_reset();
      test_alarm();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
